// File: rtl/fb_stream_reader.sv
// Read-side master for the video line/frame RAM: walks base..base+count-1 and re-times RAM data
// through a 2-entry skid FIFO onto a valid/ready stream. Define FB_STREAM_READER_LAST_EN to add m_last.
module fb_stream_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
`ifdef FB_STREAM_READER_LAST_EN
   output logic                  m_last,
`endif
   output logic [DATA_WIDTH-1:0] m_data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};

   state_t                  state_r, state_s;
   logic                    busy_r, done_r;
   logic                    accept_s, issue_s, done_s;
   logic [ADDR_WIDTH-1:0]   addr_r, raddr_r;
   logic [ADDR_WIDTH:0]     remain_r;
   logic                    inflight_r;
   logic [1:0]              occ_r, occ_next_s;
   logic [2:0]              level_s;
   logic                    pop_s;
   logic [DATA_WIDTH-1:0]   head_r, tail_r;

   assign m_valid    = (occ_r != 2'd0);
   assign m_data     = head_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign pop_s      = m_valid & m_ready;
   // Words held or owed to the FIFO once this cycle's pop has left; a read may issue only below 2.
   assign level_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
   assign occ_next_s = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
   assign raddr      = issue_s ? addr_r : raddr_r;

   // Next-state, read-issue and completion decode
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      issue_s  = 1'b0;
      done_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (count != CNT_ZERO) begin
                  accept_s = 1'b1;
                  state_s  = ST_RUN;
               end else begin
                  done_s = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (level_s < 3'd2) begin
               issue_s = 1'b1;
               if (remain_r == CNT_ONE) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (occ_next_s == 2'd0) begin
               state_s = ST_IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_IDLE);
         done_r  <= done_s;
      end
   end

   // Command address/count tracking and in-flight read flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r     <= {ADDR_WIDTH{1'b0}};
         raddr_r    <= {ADDR_WIDTH{1'b0}};
         remain_r   <= CNT_ZERO;
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (accept_s) begin
            addr_r   <= base;
            remain_r <= count;
         end else if (issue_s) begin
            raddr_r  <= addr_r;
            addr_r   <= addr_r + ADDR_ONE;
            remain_r <= remain_r - CNT_ONE;
         end else begin
            addr_r   <= addr_r;
            remain_r <= remain_r;
         end
      end
   end

   // Two-entry skid FIFO: head_r drives the stream, tail_r absorbs one word of backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r  <= 2'd0;
         head_r <= {DATA_WIDTH{1'b0}};
         tail_r <= {DATA_WIDTH{1'b0}};
      end else begin
         occ_r <= occ_next_s;
         case ({inflight_r, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  head_r <= rdata;
               end else begin
                  tail_r <= rdata;
               end
            end
            2'b01: begin
               head_r <= tail_r;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  head_r <= rdata;
               end else begin
                  head_r <= tail_r;
                  tail_r <= rdata;
               end
            end
            default: begin
               head_r <= head_r;
            end
         endcase
      end
   end

`ifdef FB_STREAM_READER_LAST_EN
   logic inflight_last_r, head_last_r, tail_last_r;

   assign m_last = head_last_r & m_valid;

   // Final-word flag travels with its read and FIFO entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_last_r <= 1'b0;
         head_last_r     <= 1'b0;
         tail_last_r     <= 1'b0;
      end else begin
         inflight_last_r <= issue_s && (remain_r == CNT_ONE);
         case ({inflight_r, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  head_last_r <= inflight_last_r;
               end else begin
                  tail_last_r <= inflight_last_r;
               end
            end
            2'b01: begin
               head_last_r <= tail_last_r;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  head_last_r <= inflight_last_r;
               end else begin
                  head_last_r <= tail_last_r;
                  tail_last_r <= inflight_last_r;
               end
            end
            default: begin
               head_last_r <= head_last_r;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_fb_stream_reader.sv
// Scoreboard bench for fb_stream_reader: stimulus pushes expected words, a negedge monitor checks them.
module tb_fb_stream_reader;
   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   count;
   logic          busy, done;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata = 8'h00;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
`ifdef FB_STREAM_READER_LAST_EN
   logic          m_last;
`endif

   fb_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .base    (base),
      .count   (count),
      .busy    (busy),
      .done    (done),
      .raddr   (raddr),
      .rdata   (rdata),
      .m_valid (m_valid),
      .m_ready (m_ready),
`ifdef FB_STREAM_READER_LAST_EN
      .m_last  (m_last),
`endif
      .m_data  (m_data)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:255];
   always @(posedge clk) rdata <= mem[raddr];

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         hs_count = 0;
   int         last_hs_cyc = 0;
   bit         rnd_mode = 1'b0;
   logic [8:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // m_ready driver: held high, or a pseudo-random pattern in rnd_mode
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every handshake, checks stall stability
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      logic [8:0] e;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 32'(m_valid), 32'd1);
               check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
               hs_count++;
               last_hs_cyc = cyc;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word: got %0h required no word (cycle %0d)", m_data, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("data", 32'(m_data), 32'(e[7:0]));
`ifdef FB_STREAM_READER_LAST_EN
                  check("last", 32'(m_last), 32'(e[8]));
`endif
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
   end

   task automatic push_model(input logic [7:0] b, input int n);
      logic [7:0] a;
      for (int i = 0; i < n; i++) begin
         a = 8'(int'(b) + i);
         exp_q.push_back({(i == n - 1), mem[a]});
      end
   endtask

   // One command: start pulse, optional latency / duplicate-start probes, bounded wait for done
   task automatic run_cmd(input logic [7:0] b, input logic [8:0] n, input bit lat, input bit dup);
      bit seen;
      @(posedge clk);
      #1;
      start = 1'b1;
      base  = b;
      count = n;
      @(posedge clk);
      #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (k == 0 && n != 9'd0) begin
            check("busy_after_start", 32'(busy), 32'd1);
            check("raddr_first", 32'(raddr), 32'(b));
         end
         if (lat && k == 1) check("lat_no_valid_e1", 32'(m_valid), 32'd0);
         if (lat && k == 2) check("lat_valid_e2", 32'(m_valid), 32'd1);
         if (dup && k == 3) begin
            start = 1'b1;
            base  = 8'h40;
            count = 9'd3;
         end
         if (dup && k == 4) start = 1'b0;
         if (done) begin
            seen = 1'b1;
            check("busy_with_done", 32'(busy), 32'd0);
            check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
            if (n == 9'd0) begin
               check("done_latency_cnt0", 32'(k), 32'd0);
               check("no_valid_cnt0", 32'(m_valid), 32'd0);
            end else begin
               check("done_after_last_hs", 32'(cyc), 32'(last_hs_cyc + 1));
            end
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      repeat (5) @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int hs0;
      int dones;
      int valids;
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      int dones;
      int valids;
      for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
      rst_n = 1'b0;
      start = 1'b0;
      base  = 8'h00;
      count = 9'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_raddr", 32'(raddr), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      rst_n = 1'b1;

      // base 0x10: hand-computed mem[a] = a ^ 0x5A
      exp_q.push_back({1'b0, 8'h4A});
      exp_q.push_back({1'b0, 8'h4B});
      exp_q.push_back({1'b0, 8'h48});
      exp_q.push_back({1'b1, 8'h49});
      run_cmd(8'h10, 9'd4, 1'b1, 1'b0);

      // wrap past the top of memory: 0xFE,0xFF,0x00,0x01
      exp_q.push_back({1'b0, 8'hA4});
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b0, 8'h5A});
      exp_q.push_back({1'b1, 8'h5B});
      run_cmd(8'hFE, 9'd4, 1'b1, 1'b0);

      rnd_mode = 1'b1;
      hs0 = hs_count;
      push_model(8'h30, 5);
      run_cmd(8'h30, 9'd5, 1'b0, 1'b0);
      check("rnd_handshakes", 32'(hs_count - hs0), 32'd5);
      rnd_mode = 1'b0;

      run_cmd(8'h00, 9'd0, 1'b0, 1'b0);

      hs0 = hs_count;
      push_model(8'h50, 8);
      run_cmd(8'h50, 9'd8, 1'b0, 1'b1);
      check("dup_start_words", 32'(hs_count - hs0), 32'd8);

      // asynchronous reset after the 2nd of 8 words
      hs0 = hs_count;
      push_model(8'h80, 8);
      @(posedge clk);
      #1;
      start = 1'b1;
      base  = 8'h80;
      count = 9'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 50 && hs_count < hs0 + 2; k++) @(negedge clk);
      check("reached_two_words", 32'(hs_count - hs0), 32'd2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(m_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      dones  = 0;
      valids = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) dones++;
         if (m_valid) valids++;
      end
      check("no_done_after_reset", 32'(dones), 32'd0);
      check("no_valid_after_reset", 32'(valids), 32'd0);
      push_model(8'h20, 2);
      run_cmd(8'h20, 9'd2, 1'b1, 1'b0);

`ifdef FB_STREAM_READER_LAST_EN
      push_model(8'h60, 3);
      run_cmd(8'h60, 9'd3, 1'b0, 1'b0);
`endif
      hs0 = hs_count;
      push_model(8'h00, 256);
      run_cmd(8'h00, 9'd256, 1'b0, 1'b0);
      check("full_mem_words", 32'(hs_count - hs0), 32'd256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
